// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
// Shared definitions for the BCD display driver:
//   - conversion FSM state encoding
//   - digit-scan index encoding
//   - 7-segment pattern table (active-high, bit order {g,f,e,d,c,b,a})
//   - double-dabble nibble adjust helper
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_e;

    // All segments dark, active-high view.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high 7-segment pattern for one BCD digit. Codes above 9 cannot
    // come out of the converter; they decode to dark rather than garbage.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would reach 10+ after
    // the next left shift, so pre-add 3 to carry it into the next digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit
// per clock) with a single-entry, last-value-wins pending slot.
//
// Ports
//   clk    in   system clock, posedge
//   rstb   in   asynchronous active-low reset
//   value  in   [7:0] binary value to convert
//   load   in   strobe: sample value this cycle
//   busy   out  conversion in progress (9 cycles per conversion)
//   done   out  one-cycle pulse in the cycle bcd takes a new value
//   bcd    out  [11:0] {hundreds,tens,ones} of last completed conversion
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  sr_q;
    logic [11:0] acc_q;
    logic        pend_q;
    logic [7:0]  pend_val_q;
    logic        busy_q;
    logic        done_q;
    logic [11:0] bcd_q;

    // One double-dabble iteration: adjust every BCD nibble, then shift the
    // whole {accumulator, shift register} pair left by one.
    logic [19:0] dd_step;

    always_comb begin
        dd_step = {dd_adjust(acc_q[11:8]), dd_adjust(acc_q[7:4]),
                   dd_adjust(acc_q[3:0]), sr_q} << 1;
    end

    // NOTE: sequential state is written with non-blocking (<=) assignments only,
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            sr_q       <= 8'd0;
            acc_q      <= 12'd0;
            pend_q     <= 1'b0;
            pend_val_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 12'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A fresh load is newer than anything parked in the
                    // pending slot, so it takes priority.
                    if (load || pend_q) begin
                        sr_q    <= load ? value : pend_val_q;
                        acc_q   <= 12'd0;
                        cnt_q   <= 3'd0;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    acc_q <= dd_step[19:8];
                    sr_q  <= dd_step[7:0];
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= ST_DONE;
                    end
                    if (load) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= value;
                    end
                end

                ST_DONE: begin
                    // A parked value is started from IDLE on the next edge,
                    // so back-to-back results are a full 10 clocks apart.
                    bcd_q   <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (load) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= value;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_display_driver.sv
// ---------------------------------------------------------------------------
// bcd_display_driver
// Converts an 8-bit binary count to BCD and time-multiplexes the three
// digits onto a single 7-segment bus with optional leading-zero blanking.
//
// Parameters
//   SCAN_DIV        clocks each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW  1: seg/an drive 0 = on; 0: 1 = on
//   BLANK_LEADING   1: suppress leading zeros (ones digit always shown)
//
// Ports
//   clk    in   system clock, posedge
//   rstb   in   asynchronous active-low reset
//   value  in   [7:0] binary value to display
//   load   in   strobe: sample value this cycle
//   busy   out  conversion in progress
//   done   out  one-cycle pulse when bcd updates
//   bcd    out  [11:0] {hundreds,tens,ones} of last completed conversion
//   seg    out  [6:0] {g,f,e,d,c,b,a} segment drive
//   an     out  [2:0] one-hot digit enable: [0]=ones [1]=tens [2]=hundreds
// ---------------------------------------------------------------------------
module bcd_display_driver
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
)
(
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int unsigned        PRESC_W     = $clog2(SCAN_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(SCAN_DIV - 1);
    localparam logic [6:0]         SEG_PIN_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [2:0]         AN_PIN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [PRESC_W-1:0] presc_q;
    digit_e             dig_q;
    logic [6:0]         seg_d, seg_q;
    logic [2:0]         an_d,  an_q;

    logic [3:0]         nibble;
    logic               blank;
    logic [6:0]         seg_ah;
    logic [2:0]         an_ah;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rstb  (rstb),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Scan timing: each digit is held for SCAN_DIV clocks.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            presc_q <= '0;
            dig_q   <= DIG_ONES;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            case (dig_q)
                DIG_ONES: dig_q <= DIG_TENS;
                DIG_TENS: dig_q <= DIG_HUNDREDS;
                default:  dig_q <= DIG_ONES;
            endcase
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Digit select and blanking. The display reads only the committed bcd,
    // never the converter's working accumulator, so it cannot flicker
    // through intermediate values mid-conversion.
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nibble = bcd[3:0];
        blank  = 1'b0;
        an_ah  = 3'b001;
        case (dig_q)
            DIG_TENS: begin
                nibble = bcd[7:4];
                an_ah  = 3'b010;
                blank  = BLANK_LEADING && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            DIG_HUNDREDS: begin
                nibble = bcd[11:8];
                an_ah  = 3'b100;
                blank  = BLANK_LEADING && (bcd[11:8] == 4'd0);
            end
            default: begin
                nibble = bcd[3:0];
                an_ah  = 3'b001;
                blank  = 1'b0;
            end
        endcase
        seg_ah = blank ? SEG_OFF : seg_pattern(nibble);
        seg_d  = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
        an_d   = SEG_ACTIVE_LOW ? ~an_ah  : an_ah;
    end

    // Registered pin drivers: seg/an follow the digit index one clock later.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seg_q <= SEG_PIN_OFF;
            an_q  <= AN_PIN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
